// File: rtl/shift_reg_univ.sv
// Universal WIDTH-bit register with eight mode operations and a
// self-sequencing serial-transfer engine that shifts a full word.
module shift_reg_univ #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    input  logic             start,
    input  logic             xfer_dir,
    output logic [WIDTH-1:0] q,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             last;

    assign last = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
            q_q     <= q_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    dir_d   = xfer_dir;
                end
            end
            SHIFT: begin
                if (last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Engine owns q while shifting; start beats any mode operation.
    always_comb begin
        q_d = q_q;
        if (state_q == SHIFT) begin
            if (dir_q) q_d = {sin, q_q[WIDTH-1:1]};
            else       q_d = {q_q[WIDTH-2:0], sin};
        end else if (!start && en) begin
            case (mode)
                3'b000:  q_d = q_q;
                3'b001:  q_d = d;
                3'b010:  q_d = {q_q[WIDTH-2:0], sin};
                3'b011:  q_d = {sin, q_q[WIDTH-1:1]};
                3'b100:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                3'b101:  q_d = {q_q[0], q_q[WIDTH-1:1]};
                3'b110:  q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                3'b111:  q_d = '0;
                default: q_d = q_q;
            endcase
        end
    end

    assign q        = q_q;
    assign sout_msb = q_q[WIDTH-1];
    assign sout_lsb = q_q[0];
    assign busy     = (state_q == SHIFT);
    assign done     = done_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ with a word-level reference model
// checked every cycle plus literal expectations at key points.
module tb_shift_reg_univ;

    localparam int W = 8;
    localparam int unsigned MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic [2:0]   mode = 3'b000;
    logic [W-1:0] d = '0;
    logic         sin = 1'b0;
    logic         start = 1'b0;
    logic         xfer_dir = 1'b0;
    logic [W-1:0] q;
    logic         sout_msb, sout_lsb, busy, done;

    int n_chk = 0;
    int n_fail = 0;

    int unsigned mq = 0;
    int          rem = 0;
    logic        mdone = 1'b0;
    logic        mdir = 1'b0;

    shift_reg_univ #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d),
        .sin(sin), .start(start), .xfer_dir(xfer_dir), .q(q),
        .sout_msb(sout_msb), .sout_lsb(sout_lsb),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic int unsigned mode_op(input int unsigned m,
                                            input logic [2:0] md);
        int unsigned s;
        s = {31'd0, sin};
        case (md)
            3'd1: return {24'd0, d};
            3'd2: return ((m << 1) | s) & MASK;
            3'd3: return (m >> 1) | (s << (W - 1));
            3'd4: return ((m << 1) | (m >> (W - 1))) & MASK;
            3'd5: return (m >> 1) | ((m & 1) << (W - 1));
            3'd6: return (m >> 1) | (m & (1 << (W - 1)));
            3'd7: return 0;
            default: return m;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq <= 0; rem <= 0; mdone <= 1'b0; mdir <= 1'b0;
        end else begin
            mdone <= 1'b0;
            if (rem > 0) begin
                if (mdir) mq <= (mq >> 1) | ({31'd0, sin} << (W - 1));
                else      mq <= ((mq << 1) | {31'd0, sin}) & MASK;
                rem <= rem - 1;
                if (rem == 1) mdone <= 1'b1;
            end else if (start) begin
                rem  <= W;
                mdir <= xfer_dir;
            end else if (en) begin
                mq <= mode_op(mq, mode);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_q", {24'd0, q}, mq);
        chk("model_msb", {31'd0, sout_msb}, (mq >> (W - 1)) & 1);
        chk("model_lsb", {31'd0, sout_lsb}, mq & 1);
        chk("model_busy", {31'd0, busy}, (rem > 0) ? 1 : 0);
        chk("model_done", {31'd0, done}, {31'd0, mdone});
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic op(input logic [2:0] m, input logic [W-1:0] dv);
        mode = m;
        d = dv;
        cyc();
    endtask

    logic [7:0] bits;

    initial begin
        #2;
        chk("rst_q", {24'd0, q}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        chk("rst_done", {31'd0, done}, 32'h0);
        cyc();
        cyc();
        rst_n = 1'b1;
        en = 1'b1;

        op(3'b001, 8'hA5);
        sin = 1'b1;
        op(3'b010, 8'h00);
        chk("t1_shl", {24'd0, q}, 32'h4B);
        chk("t1_msb", {31'd0, sout_msb}, 32'h0);
        chk("t1_lsb", {31'd0, sout_lsb}, 32'h1);

        op(3'b001, 8'hA5);
        op(3'b101, 8'h00);
        chk("t2_rotr", {24'd0, q}, 32'hD2);
        op(3'b100, 8'h00);
        chk("t2_rotl", {24'd0, q}, 32'hA5);
        op(3'b001, 8'h85);
        op(3'b110, 8'h00);
        chk("t2_asr", {24'd0, q}, 32'hC2);
        sin = 1'b1;
        op(3'b011, 8'h00);
        chk("t2_shr", {24'd0, q}, 32'hE1);

        op(3'b001, 8'h3C);
        en = 1'b0;
        for (int m = 0; m < 8; m++) op(3'(m), 8'hFF);
        chk("t3_en0", {24'd0, q}, 32'h3C);
        en = 1'b1;
        op(3'b111, 8'h00);
        chk("t3_clr", {24'd0, q}, 32'h00);

        bits = 8'b1011_0010;
        mode = 3'b000;
        start = 1'b1;
        xfer_dir = 1'b0;
        cyc();
        start = 1'b0;
        mode = 3'b001;
        d = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            chk("t4_busy", {31'd0, busy}, 32'h1);
            chk("t4_nodone", {31'd0, done}, 32'h0);
            sin = bits[7 - i];
            cyc();
        end
        chk("t4_q", {24'd0, q}, 32'hB2);
        chk("t4_busy_end", {31'd0, busy}, 32'h0);
        chk("t4_done", {31'd0, done}, 32'h1);
        mode = 3'b000;
        cyc();
        chk("t4_done_clr", {31'd0, done}, 32'h0);
        chk("t4_q_hold", {24'd0, q}, 32'hB2);

        op(3'b001, 8'h81);
        mode = 3'b000;
        sin = 1'b0;
        start = 1'b1;
        xfer_dir = 1'b1;
        cyc();
        start = 1'b0;
        xfer_dir = 1'b0;
        for (int i = 0; i < 7; i++) cyc();
        chk("t5_q7", {24'd0, q}, 32'h01);
        cyc();
        chk("t5_q", {24'd0, q}, 32'h00);
        chk("t5_done", {31'd0, done}, 32'h1);
        start = 1'b1;
        xfer_dir = 1'b1;
        cyc();
        start = 1'b0;
        chk("t5_busy2", {31'd0, busy}, 32'h1);
        chk("t5_done2", {31'd0, done}, 32'h0);
        sin = 1'b1;
        for (int i = 0; i < 8; i++) cyc();
        chk("t5_q2", {24'd0, q}, 32'hFF);
        chk("t5_done3", {31'd0, done}, 32'h1);

        op(3'b001, 8'hFF);
        mode = 3'b000;
        sin = 1'b0;
        start = 1'b1;
        xfer_dir = 1'b0;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        chk("t6_q3", {24'd0, q}, 32'hF8);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_q", {24'd0, q}, 32'h0);
        chk("t6_rst_busy", {31'd0, busy}, 32'h0);
        chk("t6_rst_done", {31'd0, done}, 32'h0);
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("t6_no_done", {31'd0, done}, 32'h0);
        end
        chk("t6_idle", {31'd0, busy}, 32'h0);
        sin = 1'b1;
        start = 1'b1;
        xfer_dir = 1'b1;
        cyc();
        start = 1'b0;
        chk("t6_busy", {31'd0, busy}, 32'h1);
        for (int i = 0; i < 8; i++) cyc();
        chk("t6_q", {24'd0, q}, 32'hFF);
        chk("t6_done", {31'd0, done}, 32'h1);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_reg_univ.md
Name: shift_reg_univ

Overview:
Parametrised universal register. It generalises the single-bit storage element to a WIDTH-bit edge-triggered register with eight operating modes and a built-in serial-transfer engine that shifts a full word without sequencing from the host. It is used in the music player datapath for tone/sample word storage and serial DAC/peripheral shifting. It replaces ad-hoc per-bit latch chains.

Parameters:
WIDTH, 8, register width in bits (legal range 2..32)

Ports:
clk       input   1      clock; all state updates on rising edge
rst_n     input   1      reset, asynchronous assert, active-low
en        input   1      enables mode operations; does not gate the serial engine
mode      input   3      operation select (see Behaviour)
d         input   WIDTH  parallel load data
sin       input   1      serial input bit for shift modes and serial transfer
start     input   1      request a WIDTH-bit serial transfer
xfer_dir  input   1      serial transfer direction: 0 = left, 1 = right; sampled at start
q         output  WIDTH  register contents
sout_msb  output  1      combinational, equals q[WIDTH-1]
sout_lsb  output  1      combinational, equals q[0]
busy      output  1      high while the serial engine is shifting
done      output  1      one-cycle pulse after the last serial shift

Behaviour:
- Reset (rst_n=0, asynchronous): q=0, busy=0, done=0, state=IDLE, counter=0, latched direction=0. Outputs hold these values while rst_n=0. The first update occurs on the first rising edge after rst_n rises.
- Mode operations apply only when state=IDLE, en=1 and start=0. Each takes effect on the rising edge; latency is 1 cycle.
  - 000 hold: q unchanged.
  - 001 load: q <= d.
  - 010 shift left: q <= {q[W-2:0], sin}.
  - 011 shift right: q <= {sin, q[W-1:1]}.
  - 100 rotate left: q <= {q[W-2:0], q[W-1]}.
  - 101 rotate right: q <= {q[0], q[W-1:1]}.
  - 110 arithmetic shift right: q <= {q[W-1], q[W-1:1]}. sin is ignored.
  - 111 clear: q <= 0.
- en=0 in IDLE: q holds regardless of mode.
- Serial engine FSM, two states:
  - IDLE, start=1: on the edge, go to SHIFT, counter <= 0, latch xfer_dir. No mode operation and no shift on this edge; start has priority over mode.
  - SHIFT: each edge shifts by the latched direction, inserting sin (left inserts at bit 0, right inserts at bit WIDTH-1), then counter <= counter+1. On the edge where counter==WIDTH-1, perform the final shift, go to IDLE and set done=1.
  - busy = (state==SHIFT), driven from registered state. It is high for exactly WIDTH cycles.
  - done is a registered bit. It is high for exactly one cycle, the cycle immediately after the last shift, when busy=0. It clears on the next edge.
  - While busy: mode, en, d, start and xfer_dir are ignored. q changes only by the engine.
  - In the done cycle the FSM is already IDLE. start there is accepted, so back-to-back transfers are allowed. Mode operations are also honoured in that cycle.
- Counter width is clog2(WIDTH). It never exceeds WIDTH-1.
- Async reset mid-transfer aborts immediately: busy=0, done=0, q=0. No done pulse is generated for the aborted transfer.
- sout_msb and sout_lsb are pure functions of q, with no extra delay.

Test Plan:
1. WIDTH=8, reset, en=1. Load d=0xA5, then one edge of mode=010 with sin=1 -> q=0x4B, sout_msb=0, sout_lsb=1.
2. q=0xA5. One edge of mode=101 -> q=0xD2. Then one edge of mode=100 -> q=0xA5. Load 0x85, then one edge of mode=110 -> q=0xC2.
3. q=0x3C, en=0. Cycle through all eight modes, one edge each -> q stays 0x3C. Then en=1, mode=111 -> q=0x00.
4. q=0x00. Pulse start with xfer_dir=0, then drive sin = 1,0,1,1,0,0,1,0 on successive SHIFT edges -> busy high for exactly 8 cycles, q=0xB2, done high for exactly 1 cycle. During this, mode=001 with d=0xFF is applied and has no effect.
5. Load 0x81. Start a transfer with xfer_dir=1 and sin held 0. Assert start again during the done cycle -> 8 shifts give q=0x00. The second transfer begins with no idle gap and busy re-asserts on the next cycle.
6. Load 0xFF. Start a transfer, then drop rst_n asynchronously after the 3rd shift, between clock edges -> q=0, busy=0 immediately. No done pulse follows after rst_n is released, and a new transfer starts normally.
